crossyroad_game_ctrl: RTL and testbench
=======================================

Name: crossyroad_game_ctrl

Overview:
Game-flow sequencer for the Crossy Road VGA game. It sits between the player button inputs and the VGA renderer. It owns the game state machine, the player grid position, the score and the world-scroll request. All state advances only on the per-frame tick, so the renderer sees stable values for a whole frame.

Parameters:
GRID_W, 16, playfield width in tiles (640 px / 40 px)
GRID_H, 12, playfield height in tiles (480 px / 40 px)
ROW_LIMIT, 5, highest row the player sprite may occupy; moving up from this row scrolls the world instead
MOVE_COOLDOWN, 8, frames a successful move blocks further moves
DEATH_FRAMES, 60, frames spent in DYING before OVER

Ports:
clk  in  1  system clock (pixel clock domain)
sys_rst  in  1  synchronous, active-high reset
frame_tick  in  1  single-cycle pulse at start of vertical blank
move  in  4  {up,down,left,right}; active-high buttons, already synchronised to clk
collision  in  1  level from renderer; high on any active-video cycle where the player sprite overlaps a car pixel
state  out  2  00 IDLE, 01 PLAY, 10 DYING, 11 OVER
player_x  out  4  player column, 0..GRID_W-1
player_y  out  4  player row, ROW_LIMIT..GRID_H-1
score  out  8  forward moves, saturating at 255
scroll  out  1  one-cycle pulse: renderer shifts lanes down by one row
blink  out  1  player sprite blink enable, valid in DYING only

Behaviour:
- Reset (sys_rst=1 at a clk edge) sets all outputs and internal registers together:
  - state=IDLE, player_x=GRID_W/2 (8), player_y=GRID_H-1 (11), score=0, scroll=0, blink=0.
  - Clears the move latch, collision latch and both counters.
  - Reset has priority over everything, including mid-frame and during DYING.
- Move latch:
  - The block registers move each cycle. A rising edge on any bit sets pending.
  - If several bits rise, priority is up > down > left > right; the first captured direction is held until the next frame_tick.
  - A held button produces no further edges.
  - An edge on the same cycle as frame_tick is deferred to the following frame.
  - Pending is cleared at every frame_tick, whether or not it was used.
- Collision latch:
  - In PLAY, collision=1 on any cycle sets coll_seen.
  - collision on the frame_tick cycle itself is included in that tick's evaluation (ORed in).
  - coll_seen is cleared at every frame_tick.
  - collision is ignored outside PLAY.
- All state and output updates happen on the clk edge where frame_tick=1. Outputs change 1 cycle after the tick pulse is seen.
- IDLE: pending move at tick -> PLAY. The move is consumed and not applied. The cooldown counter is loaded to 0.
- PLAY, evaluated at tick in this order:
  1. If coll_seen -> DYING. death_cnt=DEATH_FRAMES-1. No move is applied.
  2. Else, if cooldown>0, decrement cooldown and discard pending.
  3. Else apply pending:
     - up: if player_y>ROW_LIMIT, player_y-1; else player_y is unchanged and scroll=1 for exactly 1 cycle. Either way score+1, saturating at 255.
     - down: if player_y<GRID_H-1, player_y+1; no score change.
     - left: if player_x>0, player_x-1. right: if player_x<GRID_W-1, player_x+1.
     - A successful move (position changed or scroll issued) loads cooldown=MOVE_COOLDOWN-1.
     - A move blocked at a wall changes nothing and does not load cooldown.
- DYING:
  - At each tick: if death_cnt==0 -> OVER; else death_cnt-1.
  - blink=death_cnt[2]. The position and score are frozen.
  - Move edges are latched but ignored.
- OVER:
  - score and position are held; blink=0.
  - Pending move at tick -> IDLE: player_x=8, player_y=11, score=0.
- scroll is high only for the cycle after a tick in PLAY; it is never high in any other state.
- Internal widths: cooldown counter is ceil(log2(MOVE_COOLDOWN)) bits; death_cnt is ceil(log2(DEATH_FRAMES)) bits.

Test Plan:
- Reset then idle ticks: state=00, player_x=8, player_y=11, score=0, scroll=0 on every cycle. Pulse up, then tick: state=01, position unchanged.
- PLAY with up pulsed before each of 8 ticks, cooldown disabled by spacing presses 8 ticks apart:
  - player_y steps 11->10->9->8->7->6->5.
  - The next up gives player_y=5, one scroll pulse and score=7.
  - Verify scroll is exactly 1 cycle wide.
- Cooldown: up before tick N (moves), up again before tick N+3 -> ignored. Up before tick N+8 -> applied.
- Walls: at player_x=0 press left -> no change and no cooldown; an immediate right before the next tick -> player_x=1. At player_y=11, down -> no change.
- Collision and death:
  - A one-cycle collision mid-frame in PLAY, plus an up pending on the same tick -> state=10 and no move applied.
  - blink toggles every 4 ticks; after 60 ticks state=11.
  - Up then tick -> state=00, score=0, player (8,11).
- Edge cases:
  - up and right rising together -> only up applied.
  - A move edge on the frame_tick cycle is applied at the next tick.
  - sys_rst asserted during DYING -> IDLE values the next cycle.
  - score held at 255 saturates on a further up.

Source files
------------

// File: rtl/crossyroad_game_ctrl.sv
// ----------------------------------------------------------------------------
// crossyroad_game_ctrl : frame-synchronous game-flow sequencer (state, position,
// score, world scroll) between player buttons and the VGA renderer. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module crossyroad_game_ctrl #(
  parameter int GRID_W        = 16,
  parameter int GRID_H        = 12,
  parameter int ROW_LIMIT     = 5,
  parameter int MOVE_COOLDOWN = 8,
  parameter int DEATH_FRAMES  = 60
) (
  input  logic       clk,
  input  logic       sys_rst,
  input  logic       frame_tick,
  input  logic [3:0] move,
  input  logic       collision,
  output logic [1:0] state,
  output logic [3:0] player_x,
  output logic [3:0] player_y,
  output logic [7:0] score,
  output logic       scroll,
  output logic       blink
);

  localparam int CD_W = (MOVE_COOLDOWN > 1) ? $clog2(MOVE_COOLDOWN) : 1;
  localparam int DC_W = (DEATH_FRAMES > 1) ? $clog2(DEATH_FRAMES) : 1;

  localparam logic [3:0]      c_x_home  = 4'(GRID_W / 2);
  localparam logic [3:0]      c_y_home  = 4'(GRID_H - 1);
  localparam logic [3:0]      c_x_max   = 4'(GRID_W - 1);
  localparam logic [3:0]      c_y_max   = 4'(GRID_H - 1);
  localparam logic [3:0]      c_y_limit = 4'(ROW_LIMIT);
  localparam logic [CD_W-1:0] c_cd_load = CD_W'(MOVE_COOLDOWN - 1);
  localparam logic [DC_W-1:0] c_dc_load = DC_W'(DEATH_FRAMES - 1);

  localparam logic [1:0] c_dir_up    = 2'd0;
  localparam logic [1:0] c_dir_down  = 2'd1;
  localparam logic [1:0] c_dir_left  = 2'd2;
  localparam logic [1:0] c_dir_right = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_PLAY  = 2'b01,
    S_DYING = 2'b10,
    S_OVER  = 2'b11
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [3:0]      r_move_q, w_rise;
  logic            r_pend, r_coll, w_coll;
  logic [1:0]      r_dir, w_rise_dir;
  logic [3:0]      r_x, r_y, w_x_nxt, w_y_nxt;
  logic [7:0]      r_score, w_score_nxt;
  logic            r_scroll, w_scroll_nxt;
  logic [CD_W-1:0] r_cd, w_cd_nxt;
  logic [DC_W-1:0] r_dc, w_dc_nxt;

  always_comb begin
    w_rise     = move & ~r_move_q;
    w_rise_dir = w_rise[3] ? c_dir_up   :
                 w_rise[2] ? c_dir_down :
                 w_rise[1] ? c_dir_left : c_dir_right;
    // A collision on the tick cycle itself still counts for this frame.
    w_coll     = r_coll | ((r_state == S_PLAY) & collision);
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_x_nxt      = r_x;
    w_y_nxt      = r_y;
    w_score_nxt  = r_score;
    w_cd_nxt     = r_cd;
    w_dc_nxt     = r_dc;
    w_scroll_nxt = 1'b0;
    if (frame_tick) begin
      case (r_state)
        S_IDLE: if (r_pend) begin
          w_state_nxt = S_PLAY;
          w_cd_nxt    = '0;
        end
        S_PLAY: begin
          if (w_coll) begin
            w_state_nxt = S_DYING;
            w_dc_nxt    = c_dc_load;
          end else if (r_cd != '0) begin
            w_cd_nxt = r_cd - 1'b1;
          end else if (r_pend) begin
            case (r_dir)
              c_dir_up: begin
                w_score_nxt = (r_score == 8'hFF) ? r_score : r_score + 8'd1;
                w_cd_nxt    = c_cd_load;
                if (r_y > c_y_limit) w_y_nxt = r_y - 4'd1;
                else                 w_scroll_nxt = 1'b1;
              end
              c_dir_down: if (r_y < c_y_max) begin
                w_y_nxt  = r_y + 4'd1;
                w_cd_nxt = c_cd_load;
              end
              c_dir_left: if (r_x > 4'd0) begin
                w_x_nxt  = r_x - 4'd1;
                w_cd_nxt = c_cd_load;
              end
              default: if (r_x < c_x_max) begin
                w_x_nxt  = r_x + 4'd1;
                w_cd_nxt = c_cd_load;
              end
            endcase
          end
        end
        S_DYING: begin
          if (r_dc == '0) w_state_nxt = S_OVER;
          else            w_dc_nxt    = r_dc - 1'b1;
        end
        default: if (r_pend) begin
          w_state_nxt = S_IDLE;
          w_x_nxt     = c_x_home;
          w_y_nxt     = c_y_home;
          w_score_nxt = 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      r_state  <= S_IDLE;
      r_move_q <= 4'd0;
      r_pend   <= 1'b0;
      r_dir    <= c_dir_up;
      r_coll   <= 1'b0;
      r_x      <= c_x_home;
      r_y      <= c_y_home;
      r_score  <= 8'd0;
      r_scroll <= 1'b0;
      r_cd     <= '0;
      r_dc     <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_move_q <= move;
      r_x      <= w_x_nxt;
      r_y      <= w_y_nxt;
      r_score  <= w_score_nxt;
      r_scroll <= w_scroll_nxt;
      r_cd     <= w_cd_nxt;
      r_dc     <= w_dc_nxt;
      // An edge arriving with the tick is kept for the next frame.
      if (frame_tick) begin
        r_pend <= |w_rise;
        r_dir  <= w_rise_dir;
      end else if (!r_pend && |w_rise) begin
        r_pend <= 1'b1;
        r_dir  <= w_rise_dir;
      end
      if (frame_tick)                              r_coll <= 1'b0;
      else if ((r_state == S_PLAY) && collision)   r_coll <= 1'b1;
    end
  end

  assign state    = r_state;
  assign player_x = r_x;
  assign player_y = r_y;
  assign score    = r_score;
  assign scroll   = r_scroll;
  assign blink    = (r_state == S_DYING) & r_dc[2];

endmodule

`default_nettype wire

// File: tb/tb_crossyroad_game_ctrl.sv
// ----------------------------------------------------------------------------
// tb_crossyroad_game_ctrl : directed table-driven bench for crossyroad_game_ctrl.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_crossyroad_game_ctrl;

  logic       clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic [3:0] move = 4'd0;
  logic       collision = 1'b0;
  logic [1:0] state;
  logic [3:0] player_x, player_y;
  logic [7:0] score;
  logic       scroll, blink;

  int n_checks = 0;
  int n_errors = 0;

  crossyroad_game_ctrl dut (
    .clk        (clk),
    .sys_rst    (sys_rst),
    .frame_tick (frame_tick),
    .move       (move),
    .collision  (collision),
    .state      (state),
    .player_x   (player_x),
    .player_y   (player_y),
    .score      (score),
    .scroll     (scroll),
    .blink      (blink)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         gap;
    logic [3:0] mv;
    logic       coll;
    logic [1:0] st;
    logic [3:0] x;
    logic [3:0] y;
    logic [7:0] sc;
    logic       scr;
  } vec_t;

  vec_t vecs[$];

  localparam logic [3:0] UP = 4'b1000, DN = 4'b0100, LF = 4'b0010, RT = 4'b0001;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
  endtask

  task automatic gap_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      cyc();
      do_tick();
    end
  endtask

  task automatic press(input logic [3:0] mv);
    move = mv;
    cyc();
    move = 4'd0;
    cyc();
  endtask

  task automatic pulse_coll();
    collision = 1'b1;
    cyc();
    collision = 1'b0;
    cyc();
  endtask

  task automatic chk_all(input string nm, input logic [1:0] st, input logic [3:0] x,
                         input logic [3:0] y, input logic [7:0] sc);
    chk({nm, ".state"}, state, st);
    chk({nm, ".x"}, player_x, x);
    chk({nm, ".y"}, player_y, y);
    chk({nm, ".score"}, score, sc);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Vector table: {gap ticks, press, collision, expected state, x, y, score, scroll}
    vecs.push_back('{0, 4'd0, 1'b0, 2'b00, 4'd8, 4'd11, 8'd0, 1'b0});
    vecs.push_back('{0, UP,   1'b0, 2'b01, 4'd8, 4'd11, 8'd0, 1'b0});
    vecs.push_back('{0, UP,   1'b0, 2'b01, 4'd8, 4'd10, 8'd1, 1'b0});
    vecs.push_back('{2, UP,   1'b0, 2'b01, 4'd8, 4'd10, 8'd1, 1'b0});
    vecs.push_back('{4, UP,   1'b0, 2'b01, 4'd8, 4'd9,  8'd2, 1'b0});
    vecs.push_back('{7, UP,   1'b0, 2'b01, 4'd8, 4'd8,  8'd3, 1'b0});
    vecs.push_back('{7, UP,   1'b0, 2'b01, 4'd8, 4'd7,  8'd4, 1'b0});
    vecs.push_back('{7, UP,   1'b0, 2'b01, 4'd8, 4'd6,  8'd5, 1'b0});
    vecs.push_back('{7, UP,   1'b0, 2'b01, 4'd8, 4'd5,  8'd6, 1'b0});
    vecs.push_back('{7, UP,   1'b0, 2'b01, 4'd8, 4'd5,  8'd7, 1'b1});
    for (int i = 7; i >= 0; i--)
      vecs.push_back('{7, LF, 1'b0, 2'b01, 4'(i), 4'd5, 8'd7, 1'b0});
    vecs.push_back('{7, LF,   1'b0, 2'b01, 4'd0, 4'd5,  8'd7, 1'b0});
    vecs.push_back('{0, RT,   1'b0, 2'b01, 4'd1, 4'd5,  8'd7, 1'b0});
    for (int i = 6; i <= 11; i++)
      vecs.push_back('{7, DN, 1'b0, 2'b01, 4'd1, 4'(i), 8'd7, 1'b0});
    vecs.push_back('{7, DN,   1'b0, 2'b01, 4'd1, 4'd11, 8'd7, 1'b0});
    vecs.push_back('{0, LF,   1'b0, 2'b01, 4'd0, 4'd11, 8'd7, 1'b0});
    vecs.push_back('{7, UP,   1'b1, 2'b10, 4'd0, 4'd11, 8'd7, 1'b0});

    cyc();
    cyc();
    sys_rst = 1'b0;
    chk_all("reset", 2'b00, 4'd8, 4'd11, 8'd0);
    chk("reset.scroll", scroll, 0);
    chk("reset.blink", blink, 0);

    for (int v = 0; v < vecs.size(); v++) begin
      gap_ticks(vecs[v].gap);
      cyc();
      if (vecs[v].mv != 4'd0) press(vecs[v].mv);
      if (vecs[v].coll) pulse_coll();
      do_tick();
      chk_all($sformatf("vec%0d", v), vecs[v].st, vecs[v].x, vecs[v].y, vecs[v].sc);
      chk($sformatf("vec%0d.scroll", v), scroll, vecs[v].scr);
      cyc();
      chk($sformatf("vec%0d.scroll_end", v), scroll, 0);
    end

    // Death countdown: 59 ticks stay in DYING, the 60th lands in OVER.
    chk("dying.blink0", blink, 0);
    begin
      int remaining = 59;
      for (int k = 1; k <= 60; k++) begin
        cyc();
        if (k == 10) press(UP);
        do_tick();
        remaining = 59 - k;
        if (k < 60) begin
          chk($sformatf("dying%0d.state", k), state, 2'b10);
          chk($sformatf("dying%0d.blink", k), blink, (remaining >> 2) & 1);
        end else begin
          chk("over.state", state, 2'b11);
          chk("over.blink", blink, 0);
        end
        if (k == 10) chk("dying.frozen_y", player_y, 11);
      end
    end
    cyc();
    do_tick();
    chk_all("over_hold", 2'b11, 4'd0, 4'd11, 8'd7);
    press(UP);
    do_tick();
    chk_all("restart", 2'b00, 4'd8, 4'd11, 8'd0);

    // Simultaneous up+right: only up applied.
    press(UP);
    do_tick();
    chk("start.state", state, 1);
    press(UP | RT);
    do_tick();
    chk_all("multi", 2'b01, 4'd8, 4'd10, 8'd1);

    // Edge on the tick cycle is deferred to the next frame.
    gap_ticks(7);
    cyc();
    move = UP;
    frame_tick = 1'b1;
    cyc();
    move = 4'd0;
    frame_tick = 1'b0;
    chk("defer.same_tick_y", player_y, 10);
    cyc();
    do_tick();
    chk_all("defer.next", 2'b01, 4'd8, 4'd9, 8'd2);

    // Reset during DYING.
    pulse_coll();
    do_tick();
    chk("rstdying.enter", state, 2);
    gap_ticks(3);
    sys_rst = 1'b1;
    cyc();
    sys_rst = 1'b0;
    chk_all("rstdying", 2'b00, 4'd8, 4'd11, 8'd0);
    chk("rstdying.blink", blink, 0);
    chk("rstdying.scroll", scroll, 0);

    // Score saturation at 255.
    cyc();
    press(UP);
    do_tick();
    for (int i = 0; i < 255; i++) begin
      gap_ticks(7);
      cyc();
      press(UP);
      do_tick();
    end
    chk_all("sat.reach", 2'b01, 4'd8, 4'd5, 8'd255);
    gap_ticks(7);
    cyc();
    press(UP);
    do_tick();
    chk_all("sat.hold", 2'b01, 4'd8, 4'd5, 8'd255);
    chk("sat.scroll", scroll, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
